// File: rtl/ep_code_converter.sv
// Registered W-bit code converter: bin->Gray, Gray->bin, excess-3, pass-through.
// Latency: 1 cycle from X/MODE sampled at a TG edge to Y/VLD after that edge.
// Backpressure: none; the output register updates on every edge with no enable.
//
// Ports:
//   TG     clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset; clears Y and VLD
//   X      input code word (W bits)
//   MODE   conversion select: 00 bin->Gray, 01 Gray->bin, 10 excess-3, 11 pass
//   Y      converted code word, registered
//   VLD    high once Y holds a conversion result (first edge after reset release)
module ep_code_converter #(
  parameter int W = 4
) (
  input  logic         TG,
  input  logic         rst_n,
  input  logic [W-1:0] X,
  input  logic [1:0]   MODE,
  output logic [W-1:0] Y,
  output logic         VLD
);

  typedef enum logic [1:0] {
    MODE_B2G  = 2'b00,
    MODE_G2B  = 2'b01,
    MODE_EX3  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  localparam logic [W-1:0] EX3_OFS = W'(3);

  logic [W-1:0] b2g;
  logic [W-1:0] g2b;
  logic [W-1:0] ex3;
  logic [W-1:0] y_d;
  logic [W-1:0] y_q;
  logic         vld_d;
  logic         vld_q;

  // Gray -> binary: bit i is the XOR of all Gray bits from the MSB down to i.
  // Written as a reduction over a shifted copy so no bit depends on another
  // bit of the same vector (keeps the comb logic free of self-reference).
  always_comb begin
    g2b = '0;
    for (int i = 0; i < W; i++) begin
      g2b[i] = ^(X >> i);
    end
  end

  always_comb begin
    b2g = X ^ (X >> 1);
    // Truncation to W bits gives the silent wrap (e.g. 13 -> 0 for W=4).
    ex3 = X + EX3_OFS;
  end

  always_comb begin
    y_d   = X;
    vld_d = 1'b1;
    case (mode_e'(MODE))
      MODE_B2G:  y_d = b2g;
      MODE_G2B:  y_d = g2b;
      MODE_EX3:  y_d = ex3;
      MODE_PASS: y_d = X;
    endcase
  end

  always_ff @(posedge TG) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign Y   = y_q;
  assign VLD = vld_q;

endmodule

// File: tb/tb_ep_code_converter.sv
module tb_ep_code_converter;

  localparam int W = 4;

  logic         TG;
  logic         rst_n;
  logic [W-1:0] X;
  logic [1:0]   MODE;
  logic [W-1:0] Y;
  logic         VLD;

  ep_code_converter #(.W(W)) dut (
    .TG   (TG),
    .rst_n(rst_n),
    .X    (X),
    .MODE (MODE),
    .Y    (Y),
    .VLD  (VLD)
  );

  initial TG = 1'b0;
  always #5 TG = ~TG;

  typedef struct {
    logic [W-1:0] y;
    logic         vld;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   n_checks   = 0;
  bit   have_hold  = 0;
  exp_t hold;

  // Reference conversion straight from the code definitions, on integers.
  function automatic int model(input int x, input int mode);
    int r;
    case (mode)
      0: r = x ^ (x >> 1);
      1: begin
        // binary = XOR of the Gray word shifted right by 0..W-1
        r = 0;
        for (int s = 0; s < W; s++) r = r ^ (x >> s);
      end
      2: r = (x + 3) % (1 << W);
      default: r = x;
    endcase
    return r % (1 << W);
  endfunction

  task automatic apply(input bit r, input int x, input int mode);
    exp_t e;
    @(negedge TG);
    rst_n = r;
    X     = x[W-1:0];
    MODE  = mode[1:0];
    vectors++;
    e.y   = r ? W'(model(x, mode)) : '0;
    e.vld = r;
    exp_q.push_back(e);
  endtask

  // Monitor: result presented after each rising edge is checked against the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge TG);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Y !== e.y) begin
          miscompares++;
          $display("FAIL y_out t=%0t got=%h want=%h", $time, Y, e.y);
        end
        if (VLD !== e.vld) begin
          miscompares++;
          $display("FAIL vld_out t=%0t got=%b want=%b", $time, VLD, e.vld);
        end
        hold      = e;
        have_hold = 1;
      end
    end
  end

  // Inputs change at the falling edge; Y must not follow them until the
  // next rising edge.
  initial begin
    forever begin
      @(negedge TG);
      #1;
      if (have_hold) begin
        n_checks++;
        if (Y !== hold.y) begin
          miscompares++;
          $display("FAIL y_hold t=%0t got=%h want=%h", $time, Y, hold.y);
        end
      end
    end
  end

  initial begin
    int gseq[16];
    rst_n = 1'b0;
    X     = '0;
    MODE  = 2'b00;

    // Reset held for 3 edges with X=F, then release: expect 8.
    for (int i = 0; i < 3; i++) apply(0, 15, 0);
    apply(1, 15, 0);

    // Binary -> Gray over all codes.
    for (int i = 0; i < 16; i++) apply(1, i, 0);

    // Gray -> binary on the Gray sequence (round trip back to 0..15).
    for (int i = 0; i < 16; i++) gseq[i] = i ^ (i >> 1);
    for (int i = 0; i < 16; i++) apply(1, gseq[i], 1);

    // Excess-3 including wrap, then pass-through.
    apply(1, 0, 2);
    apply(1, 9, 2);
    apply(1, 12, 2);
    apply(1, 13, 2);
    apply(1, 14, 2);
    apply(1, 15, 2);
    apply(1, 10, 3);

    // MODE switch with X=6 held: 5 then 4.
    apply(1, 6, 0);
    apply(1, 6, 1);

    // One-edge reset while counting, then resume.
    for (int i = 0; i < 8; i++) apply((i != 4), i, 0);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) != 0), $urandom_range(0, 15), $urandom_range(0, 3));
    end

    // Drain outstanding expectations with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge TG);
    @(negedge TG);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
    end
    if (n_checks < 12) begin
      miscompares++;
      $display("FAIL check_count got=%0d want>=12", n_checks);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
